instr_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the free-running, testbench-driven program counter ahead of `ARM_RISC`. It owns the PC and drives the combinational `ROM` address. Fetched words go into a small ordered buffer and are handed to the core over a valid/ready handshake. It adds backpressure, branch redirect with flush, halt/resume and PC wrap-around, none of which the current per-cycle `pc = pc + 1` scheme provides.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/instr_fetch_unit_if.sv | 34 +++
 rtl/fetch_fifo.sv | 47 ++++
 rtl/instr_fetch_unit.sv | 71 +++++++
 tb/tb_instr_fetch_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch front end.
package fetch_pkg;

  localparam int          FETCH_ADDR_WIDTH   = 16;
  localparam int          FETCH_INSTR_WIDTH  = 32;
  localparam int          FETCH_DEPTH        = 4;
  localparam int unsigned FETCH_RESET_VECTOR = 0;
  localparam int unsigned FETCH_PC_STEP      = 1;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // Buffer entry at the default widths; the top passes its own sized copy to the FIFO.
  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0]  pc;
    logic [FETCH_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ROM, redirect/halt and core-handshake signals of the fetch unit.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) ();
  logic [ADDR_WIDTH-1:0]        rom_address;
  logic [INSTR_WIDTH-1:0]       rom_data;
  logic                         branch_taken;
  logic [ADDR_WIDTH-1:0]        branch_target;
  logic                         halt;
  logic                         instr_valid;
  logic                         instr_ready;
  logic [INSTR_WIDTH-1:0]       instruction;
  logic [ADDR_WIDTH-1:0]        instr_pc;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;
  logic                         halted;

  // Fetch unit side.
  modport master (
    output rom_address, input rom_data,
    input  branch_taken, input branch_target, input halt,
    output instr_valid, input instr_ready, output instruction, output instr_pc,
    output occupancy, output halted
  );

  // ROM / core side.
  modport slave (
    input  rom_address, output rom_data,
    output branch_taken, output branch_target, output halt,
    input  instr_valid, output instr_ready, input instruction, input instr_pc,
    input  occupancy, input halted
  );
endinterface

// File: rtl/fetch_fifo.sv
// Ordered fetch buffer: wrap-around pointers with an extra lap bit, flush beats push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = FETCH_DEPTH,
  parameter type T     = fetch_entry_t
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  T                           i_data,
  output T                           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  T            r_mem [DEPTH];

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[PW-1:0]];

  // Pointer and storage update; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr[PW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC register, RUN/HALTED FSM and buffer control ahead of the core.
//   state  | meaning
//   RUN    | fetching one word per cycle when the buffer has room
//   HALTED | PC frozen, buffer still drains; leave via redirect without halt
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH   = FETCH_ADDR_WIDTH,
  parameter int          INSTR_WIDTH  = FETCH_INSTR_WIDTH,
  parameter int          DEPTH        = FETCH_DEPTH,
  parameter int unsigned RESET_VECTOR = FETCH_RESET_VECTOR,
  parameter int unsigned PC_STEP      = FETCH_PC_STEP
) (
  input logic               clock,
  input logic               reset,
  instr_fetch_unit_if.master bus
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  fetch_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  entry_t                w_wr_entry;
  entry_t                w_head;

  assign w_pop      = !w_empty && bus.instr_ready;
  assign w_push     = (r_state == RUN) && !bus.branch_taken && (!w_full || w_pop);
  assign w_wr_entry = '{pc: r_pc, instr: bus.rom_data};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.branch_taken),
    .i_data  (w_wr_entry),
    .o_head  (w_head),
    .o_count (bus.occupancy),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.rom_address = r_pc;
  assign bus.instr_valid = !w_empty;
  assign bus.instruction = w_head.instr;
  assign bus.instr_pc    = w_head.pc;
  assign bus.halted      = (r_state == HALTED);

  // PC and FSM: redirect overrides everything, halt still lets this cycle's push happen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc    <= ADDR_WIDTH'(RESET_VECTOR);
      r_state <= RUN;
    end else if (bus.branch_taken) begin
      r_pc    <= bus.branch_target;
      r_state <= bus.halt ? HALTED : RUN;
    end else begin
      if (w_push)   r_pc    <= r_pc + ADDR_WIDTH'(PC_STEP);
      if (bus.halt) r_state <= HALTED;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based reference model.
module tb_instr_fetch_unit;
  localparam int AW = 16;
  localparam int IW = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } m_entry_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  instr_fetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) bus_if ();

  instr_fetch_unit #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_VECTOR(0), .PC_STEP(1)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  function automatic logic [IW-1:0] rom_word(input logic [AW-1:0] a);
    return 32'hA000_0000 | {16'h0000, a};
  endfunction

  assign bus_if.rom_data = rom_word(bus_if.rom_address);

  // reference model state
  m_entry_t      q[$];
  logic [AW-1:0] m_pc;
  bit            m_halted;
  bit            cmp_en = 0;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc     = '0;
    m_halted = 0;
  endtask

  // One clock edge of the reference: redirect > halt; push when running with room.
  task automatic model_step(input bit rdy, input bit br, input logic [AW-1:0] tgt, input bit hlt);
    bit pop, push;
    pop = (q.size() != 0) && rdy;
    if (br) begin
      q.delete();
      m_pc     = tgt;
      m_halted = hlt;
    end else begin
      push = !m_halted && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{pc: m_pc, instr: rom_word(m_pc)});
        m_pc = m_pc + 16'd1;
      end
      if (hlt) m_halted = 1;
    end
  endtask

  // Drive inputs at the negedge, let one posedge happen, return at the next negedge.
  task automatic cycle(input bit rdy, input bit br = 0, input logic [AW-1:0] tgt = '0, input bit hlt = 0);
    bus_if.instr_ready   = rdy;
    bus_if.branch_taken  = br;
    bus_if.branch_target = tgt;
    bus_if.halt          = hlt;
    @(posedge clock);
    model_step(rdy, br, tgt, hlt);
    @(negedge clock);
  endtask

  task automatic sync_reset();
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic mid_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_valid", bus_if.instr_valid, 0);
    chk("async_occ",   bus_if.occupancy, 0);
    chk("async_addr",  bus_if.rom_address, 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Compare the DUT against the model every cycle the outputs are meaningful.
  always @(negedge clock) begin
    if (cmp_en && reset) begin
      chk("valid",       bus_if.instr_valid, (q.size() != 0));
      chk("occupancy",   bus_if.occupancy, q.size());
      chk("halted",      bus_if.halted, m_halted);
      chk("rom_address", bus_if.rom_address, m_pc);
      if (q.size() != 0) begin
        chk("instr_pc",    bus_if.instr_pc, q[0].pc);
        chk("instruction", bus_if.instruction, q[0].instr);
      end
    end
  end

  initial begin
    bus_if.instr_ready   = 0;
    bus_if.branch_taken  = 0;
    bus_if.branch_target = '0;
    bus_if.halt          = 0;
    model_reset();
    #1;
    chk("rst_addr",  bus_if.rom_address, 0);
    chk("rst_valid", bus_if.instr_valid, 0);
    chk("rst_occ",   bus_if.occupancy, 0);
    chk("rst_instr", bus_if.instruction, 0);
    chk("rst_pc",    bus_if.instr_pc, 0);
    chk("rst_halt",  bus_if.halted, 0);
    @(negedge clock);
    reset  = 1'b1;
    cmp_en = 1;

    // reset release, streaming
    for (int i = 0; i < 4; i++) begin
      cycle(1);
      chk("rel_valid", bus_if.instr_valid, 1);
      chk("rel_pc",    bus_if.instr_pc, i);
      chk("rel_instr", bus_if.instruction, 32'hA000_0000 + i);
    end

    // backpressure to full, then drain in order
    sync_reset();
    for (int i = 0; i < 6; i++) cycle(0);
    chk("bp_occ",  bus_if.occupancy, 4);
    chk("bp_addr", bus_if.rom_address, 4);
    for (int i = 0; i < 6; i++) begin
      chk("bp_pc", bus_if.instr_pc, i);
      cycle(1);
    end

    // redirect with 3 buffered
    sync_reset();
    for (int i = 0; i < 3; i++) cycle(0);
    chk("br_occ_pre", bus_if.occupancy, 3);
    cycle(0, 1, 16'h0100);
    chk("br_valid", bus_if.instr_valid, 0);
    chk("br_occ",   bus_if.occupancy, 0);
    cycle(1);
    chk("br_pc0", bus_if.instr_pc, 16'h0100);
    cycle(1);
    chk("br_pc1", bus_if.instr_pc, 16'h0101);

    // halt with 2 buffered, drain, resume by redirect
    sync_reset();
    cycle(0);
    cycle(0);
    cycle(1, 0, '0, 1);
    chk("h_halted", bus_if.halted, 1);
    chk("h_addr",   bus_if.rom_address, 3);
    cycle(1);
    cycle(1);
    chk("h_drained", bus_if.instr_valid, 0);
    chk("h_frozen",  bus_if.rom_address, 3);
    cycle(1, 1, 16'h0020);
    chk("h_resume",  bus_if.halted, 0);
    cycle(1);
    chk("h_pc", bus_if.instr_pc, 16'h0020);

    // PC wrap
    cycle(1, 1, 16'hFFFF);
    cycle(1);
    chk("wrap0", bus_if.instr_pc, 16'hFFFF);
    cycle(1);
    chk("wrap1", bus_if.instr_pc, 16'h0000);
    cycle(1);
    chk("wrap2", bus_if.instr_pc, 16'h0001);

    // async reset with a full buffer
    for (int i = 0; i < 5; i++) cycle(0);
    chk("full_occ", bus_if.occupancy, 4);
    mid_reset();
    cycle(1);
    chk("restart_pc", bus_if.instr_pc, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] tgt;
      bit rdy, br, hlt;
      rdy = ($urandom_range(0, 9) < 7);
      br  = ($urandom_range(0, 19) == 0);
      hlt = ($urandom_range(0, 24) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFD + $urandom_range(0, 2)) : AW'($urandom);
      if ($urandom_range(0, 499) == 0) mid_reset();
      else cycle(rdy, br, tgt, hlt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
